// File: rtl/coproc_result_queue.sv
// ---------------------------------------------------------------------------
// coproc_result_queue
//
// In-order result queue between a coprocessor execution stage and the core.
// Results are pushed with their instruction id. They leave the head only once
// the core has committed (emit to the core) or killed (silently dropped) that
// id. Commit/kill status lives in a per-id table, so a commit may arrive
// before, together with or after the push of its result.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous reset, active low
//   ex_valid_i      execution stage offers a result
//   ex_ready_o      queue can take the offered result (not full)
//   ex_id_i         instruction id of the offered result
//   ex_rd_i         destination register address
//   ex_data_i       result data
//   ex_we_i         register-file write enable
//   commit_valid_i  commit/kill strobe from the core
//   commit_id_i     id being committed or killed
//   commit_kill_i   1 = kill, 0 = commit
//   result_valid_o  head result offered to the core
//   result_ready_i  core accepts the head result
//   result_id_o     head id
//   result_rd_o     head destination register
//   result_data_o   head data
//   result_we_o     head write enable
//   count_o         occupied entries
//   full_o          count_o == DEPTH
//   empty_o         count_o == 0
//
// Head state (derived each cycle from the status table):
//   state      | meaning
//   HEAD_EMPTY | no entry queued, outputs zero
//   HEAD_WAIT  | head id not yet committed, hold
//   HEAD_EMIT  | head id committed, offer to core, pop on ready
//   HEAD_DROP  | head id killed, pop this cycle without offering
// ---------------------------------------------------------------------------
module coproc_result_queue #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ex_valid_i,
    output logic                       ex_ready_o,
    input  logic [ID_WIDTH-1:0]        ex_id_i,
    input  logic [4:0]                 ex_rd_i,
    input  logic [XLEN-1:0]            ex_data_i,
    input  logic                       ex_we_i,
    input  logic                       commit_valid_i,
    input  logic [ID_WIDTH-1:0]        commit_id_i,
    input  logic                       commit_kill_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [ID_WIDTH-1:0]        result_id_o,
    output logic [4:0]                 result_rd_o,
    output logic [XLEN-1:0]            result_data_o,
    output logic                       result_we_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int NUM_IDS = 1 << ID_WIDTH;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [1:0] HEAD_EMPTY = 2'd0;
    localparam logic [1:0] HEAD_WAIT  = 2'd1;
    localparam logic [1:0] HEAD_EMIT  = 2'd2;
    localparam logic [1:0] HEAD_DROP  = 2'd3;

    logic [ID_WIDTH-1:0] id_mem   [DEPTH];
    logic [4:0]          rd_mem   [DEPTH];
    logic [XLEN-1:0]     data_mem [DEPTH];
    logic                we_mem   [DEPTH];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic [NUM_IDS-1:0]  committed;
    logic [NUM_IDS-1:0]  killed;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [ID_WIDTH-1:0] head_id;
    logic [1:0]          head_state;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign head_id = id_mem[rd_ptr];

    // Ready depends only on the registered count: a full queue never takes a
    // push, even when the head leaves in the same cycle.
    assign push = ex_valid_i && !full;

    always_comb begin
        head_state = HEAD_EMPTY;
        if (!empty) begin
            if (!committed[head_id]) begin
                head_state = HEAD_WAIT;
            end else if (killed[head_id]) begin
                head_state = HEAD_DROP;
            end else begin
                head_state = HEAD_EMIT;
            end
        end
    end

    assign pop = (head_state == HEAD_DROP) ||
                 ((head_state == HEAD_EMIT) && result_ready_i);

    // Payload storage carries no reset; empty gating keeps stale data off
    // the outputs.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr]   <= ex_id_i;
            rd_mem[wr_ptr]   <= ex_rd_i;
            data_mem[wr_ptr] <= ex_data_i;
            we_mem[wr_ptr]   <= ex_we_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A new commit for an id wins over the clear caused by the head leaving,
    // so the next use of that id keeps its early commit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            committed <= '0;
            killed    <= '0;
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                if (commit_valid_i && (commit_id_i == ID_WIDTH'(i))) begin
                    committed[i] <= 1'b1;
                    killed[i]    <= commit_kill_i;
                end else if (pop && (head_id == ID_WIDTH'(i))) begin
                    committed[i] <= 1'b0;
                    killed[i]    <= 1'b0;
                end
            end
        end
    end

    assign ex_ready_o     = !full;
    assign full_o         = full;
    assign empty_o        = empty;
    assign count_o        = count;
    assign result_valid_o = (head_state == HEAD_EMIT);
    assign result_id_o    = empty ? '0 : head_id;
    assign result_rd_o    = empty ? '0 : rd_mem[rd_ptr];
    assign result_data_o  = empty ? '0 : data_mem[rd_ptr];
    assign result_we_o    = empty ? 1'b0 : we_mem[rd_ptr];

endmodule

// File: tb/tb_coproc_result_queue.sv
// Directed bench for coproc_result_queue with default parameters
// (XLEN 32, DEPTH 4, ID_WIDTH 4). Each vector drives one cycle of inputs and
// lists the outputs expected just after that clock edge.
module tb_coproc_result_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [3:0]  ex_id_i = '0;
    logic [4:0]  ex_rd_i = '0;
    logic [31:0] ex_data_i = '0;
    logic        ex_we_i = 1'b0;
    logic        commit_valid_i = 1'b0;
    logic [3:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic [2:0]  count_o;
    logic        full_o;
    logic        empty_o;

    int errors = 0;
    int checks = 0;

    coproc_result_queue dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .ex_id_i        (ex_id_i),
        .ex_rd_i        (ex_rd_i),
        .ex_data_i      (ex_data_i),
        .ex_we_i        (ex_we_i),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .result_rd_o    (result_rd_o),
        .result_data_o  (result_data_o),
        .result_we_o    (result_we_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ev;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        cv;
        logic [3:0]  cid;
        logic        ck;
        logic        rdy;
        logic        xv;
        logic [3:0]  xid;
        logic [4:0]  xrd;
        logic [31:0] xdata;
        logic        xwe;
        logic [2:0]  xcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ev, logic [3:0] id, logic [4:0] rd, logic [31:0] data,
                                logic we, logic cv, logic [3:0] cid, logic ck, logic rdy,
                                logic xv, logic [3:0] xid, logic [4:0] xrd,
                                logic [31:0] xdata, logic xwe, logic [2:0] xcnt);
        vec_t v;
        v.ev = ev; v.id = id; v.rd = rd; v.data = data; v.we = we;
        v.cv = cv; v.cid = cid; v.ck = ck; v.rdy = rdy;
        v.xv = xv; v.xid = xid; v.xrd = xrd; v.xdata = xdata; v.xwe = xwe; v.xcnt = xcnt;
        return v;
    endfunction

    // Head fields are only defined while valid or empty; otherwise they are
    // masked out of the comparison.
    function automatic logic [63:0] pack(logic v, logic [3:0] id, logic [4:0] rd,
                                         logic [31:0] d, logic we, logic [2:0] cnt,
                                         logic fu, logic em, logic rdy, logic show);
        logic [42:0] fields;
        fields = show ? {id, rd, d, we} : '0;
        return {12'd0, v, fields, cnt, fu, em, rdy};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_valid_i     = v.ev;
        ex_id_i        = v.id;
        ex_rd_i        = v.rd;
        ex_data_i      = v.data;
        ex_we_i        = v.we;
        commit_valid_i = v.cv;
        commit_id_i    = v.cid;
        commit_kill_i  = v.ck;
        result_ready_i = v.rdy;
    endtask

    function automatic logic [63:0] dut_word(logic show);
        return pack(result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
                    count_o, full_o, empty_o, ex_ready_o, show);
    endfunction

    function automatic logic [63:0] exp_word(logic xv, logic [3:0] xid, logic [4:0] xrd,
                                             logic [31:0] xd, logic xwe, logic [2:0] xcnt);
        logic show;
        show = xv || (xcnt == 3'd0);
        return pack(xv, xid, xrd, xd, xwe, xcnt, xcnt == 3'd4, xcnt == 3'd0,
                    xcnt != 3'd4, show);
    endfunction

    initial begin
        //              ev id  rd  data          we  cv cid ck rdy  xv xid xrd xdata        xwe cnt
        // single push, later commit, pop
        vecs.push_back(mk(1, 3, 5, 32'hDEADBEEF, 1,  0, 0, 0, 0,   0, 0, 0, 0,            0, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,  1, 3, 0, 0,   1, 3, 5, 32'hDEADBEEF, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 1,   0, 0, 0, 0,            0, 0));
        // commit before push; a lone commit produces nothing
        vecs.push_back(mk(0, 0, 0, 0,            0,  1, 7, 0, 0,   0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 0,   0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 7, 7, 32'h77,       0,  0, 0, 0, 0,   1, 7, 7, 32'h77,       0, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 1,   0, 0, 0, 0,            0, 0));
        // ids 1,2,3 with 2 killed
        vecs.push_back(mk(1, 1, 1, 32'h11,       1,  0, 0, 0, 0,   0, 0, 0, 0,            0, 1));
        vecs.push_back(mk(1, 2, 2, 32'h22,       1,  0, 0, 0, 0,   0, 0, 0, 0,            0, 2));
        vecs.push_back(mk(1, 3, 3, 32'h33,       1,  1, 2, 1, 0,   0, 0, 0, 0,            0, 3));
        vecs.push_back(mk(0, 0, 0, 0,            0,  1, 1, 0, 1,   1, 1, 1, 32'h11,       1, 3));
        vecs.push_back(mk(0, 0, 0, 0,            0,  1, 3, 0, 1,   0, 0, 0, 0,            0, 2));
        vecs.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 1,   1, 3, 3, 32'h33,       1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 1,   0, 0, 0, 0,            0, 0));
        // commit in the pop cycle of the same id survives the clear
        vecs.push_back(mk(1, 5, 5, 32'h55,       1,  0, 0, 0, 0,   0, 0, 0, 0,            0, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,  1, 5, 0, 0,   1, 5, 5, 32'h55,       1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,  1, 5, 0, 1,   0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 5, 5, 32'h56,       1,  0, 0, 0, 0,   1, 5, 5, 32'h56,       1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 1,   0, 0, 0, 0,            0, 0));
        // fill across the pointer wrap, reject while full, stall, drain
        vecs.push_back(mk(1, 8, 8, 32'h80,       1,  0, 0, 0, 0,   0, 0, 0, 0,            0, 1));
        vecs.push_back(mk(1, 9, 9, 32'h90,       1,  0, 0, 0, 0,   0, 0, 0, 0,            0, 2));
        vecs.push_back(mk(1,10,10, 32'hA0,       1,  0, 0, 0, 0,   0, 0, 0, 0,            0, 3));
        vecs.push_back(mk(1,11,11, 32'hB0,       1,  0, 0, 0, 0,   0, 0, 0, 0,            0, 4));
        vecs.push_back(mk(1,12,12, 32'hC0,       1,  1, 8, 0, 0,   1, 8, 8, 32'h80,       1, 4));
        vecs.push_back(mk(0, 0, 0, 0,            0,  1, 9, 0, 0,   1, 8, 8, 32'h80,       1, 4));
        vecs.push_back(mk(0, 0, 0, 0,            0,  1,10, 0, 0,   1, 8, 8, 32'h80,       1, 4));
        vecs.push_back(mk(0, 0, 0, 0,            0,  1,11, 0, 0,   1, 8, 8, 32'h80,       1, 4));
        vecs.push_back(mk(1,12,12, 32'hC0,       1,  0, 0, 0, 1,   1, 9, 9, 32'h90,       1, 3));
        vecs.push_back(mk(1,12,12, 32'hC0,       1,  0, 0, 0, 0,   1, 9, 9, 32'h90,       1, 4));
        vecs.push_back(mk(0, 0, 0, 0,            0,  1,12, 0, 1,   1,10,10, 32'hA0,       1, 3));
        vecs.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 1,   1,11,11, 32'hB0,       1, 2));
        vecs.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 1,   1,12,12, 32'hC0,       1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 1,   0, 0, 0, 0,            0, 0));

        // reset state while held
        #12;
        chk("reset_hold", dut_word(1'b1), exp_word(0, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d", i), dut_word(vecs[i].xv || vecs[i].xcnt == 3'd0),
                exp_word(vecs[i].xv, vecs[i].xid, vecs[i].xrd, vecs[i].xdata,
                         vecs[i].xwe, vecs[i].xcnt));
        end

        // mid-operation reset: three entries, head 1 emitting, id 4 pre-committed
        drive(mk(1, 1, 1, 32'h101, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk_i); #1;
        drive(mk(1, 2, 2, 32'h102, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk_i); #1;
        drive(mk(1, 3, 3, 32'h103, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk_i); #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("pre_reset", dut_word(1'b1), exp_word(1, 1, 1, 32'h101, 1, 3));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_reset", dut_word(1'b1), exp_word(0, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("post_release", dut_word(1'b1), exp_word(0, 0, 0, 0, 0, 0));
        drive(mk(1, 4, 4, 32'h104, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk_i); #1;
        chk("stale_id4_wait", dut_word(1'b0), exp_word(0, 0, 0, 0, 0, 1));
        drive(mk(1, 1, 1, 32'h105, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk_i); #1;
        chk("stale_id1_wait", dut_word(1'b0), exp_word(0, 0, 0, 0, 0, 2));
        drive(mk(0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk_i); #1;
        chk("recommit_id4", dut_word(1'b1), exp_word(1, 4, 4, 32'h104, 1, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coproc_result_queue.md
COPROC_RESULT_QUEUE -- requirements
Module: coproc_result_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, result data width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-003 SHALL have parameter ID_WIDTH, default 4, width of instruction id.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk_i  input  1  clock, rising edge.
REQ-005 rst_ni  input  1  asynchronous reset, active low.
REQ-006 ex_valid_i  input  1  execution stage offers a result.
REQ-007 ex_ready_o  output  1  queue accepts the offered result.
REQ-008 ex_id_i  input  ID_WIDTH  instruction id of the offered result.
REQ-009 ex_rd_i  input  5  destination register address.
REQ-010 ex_data_i  input  XLEN  result data.
REQ-011 ex_we_i  input  1  register-file write enable for the result.
REQ-012 commit_valid_i  input  1  core commit/kill strobe.
REQ-013 commit_id_i  input  ID_WIDTH  id being committed or killed.
REQ-014 commit_kill_i  input  1  1 = kill, 0 = commit.
REQ-015 result_valid_o  output  1  head result offered to core.
REQ-016 result_ready_i  input  1  core accepts result.
REQ-017 result_id_o, result_rd_o, result_data_o, result_we_o  output  ID_WIDTH/5/XLEN/1  head entry fields.
REQ-018 count_o  output  $clog2(DEPTH+1)  occupied entries.
REQ-019 full_o, empty_o  output  1  count_o == DEPTH, count_o == 0.

Function
REQ-020 SHALL be an in-order circular FIFO of DEPTH entries {id, rd, data, we}, with read/write pointers wrapping modulo DEPTH.
REQ-021 SHALL drive ex_ready_o = !full_o; no bypass while full, even if the head leaves in the same cycle.
REQ-022 SHALL push on ex_valid_i && ex_ready_o at the clock edge; the entry is visible at the head no earlier than the next cycle (1-cycle minimum latency).
REQ-023 SHALL keep a status table of 2^ID_WIDTH records {committed, killed}; a commit_valid_i edge sets committed[commit_id_i] = 1 and killed[commit_id_i] = commit_kill_i.
REQ-024 SHALL accept commits that arrive before, during or after the push of the same id.
REQ-025 When not empty, the head SHALL be in one of three states, from table[head.id]: WAIT (!committed), EMIT (committed && !killed), DROP (committed && killed).
REQ-026 In WAIT, result_valid_o SHALL be 0 and the head SHALL hold.
REQ-027 In EMIT, result_valid_o SHALL be 1 with head fields on outputs; the head SHALL pop on result_ready_i; fields SHALL stay stable while valid && !ready.
REQ-028 In DROP, result_valid_o SHALL stay 0 and the head SHALL pop unconditionally in one cycle.
REQ-029 When empty, result_valid_o SHALL be 0 and result_* fields SHALL be 0.
REQ-030 On pop or drop, SHALL clear table[head.id]; a commit_valid_i to the same id in the same cycle SHALL win over the clear.
REQ-031 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-032 count_o SHALL track pushes minus pops/drops exactly; it never exceeds DEPTH or underflows.
REQ-033 A commit to an id with no entry and no pending push SHALL only update the table; it SHALL cause no output.

Reset
REQ-034 While rst_ni = 0, pointers, count_o and all table bits SHALL be 0, with result_valid_o = 0, ex_ready_o = 1, empty_o = 1, full_o = 0 and result_* = 0.
REQ-035 Assertion of reset mid-operation SHALL discard all entries and table state asynchronously; the first cycle after release SHALL behave as an empty queue.

Verification
REQ-036 Push id 3 (rd 5, data 0xDEADBEEF, we 1) -> commit id 3 next cycle -> result_valid_o = 1 the following cycle with rd 5 and data 0xDEADBEEF; pop on ready leaves empty_o = 1.
REQ-037 Commit id 7 two cycles before pushing id 7 -> result_valid_o = 1 the cycle after the push.
REQ-038 Push ids 1,2,3, kill 2, commit 1 and 3, ready held 1 -> outputs id 1 then id 3; id 2 is never valid; count_o ends 0.
REQ-039 Push DEPTH entries with no commit -> full_o = 1, ex_ready_o = 0, a further ex_valid_i is not accepted; commit all with ready = 0 -> head stable; release ready -> in-order drain with correct pointer wrap.
REQ-040 Full queue, head EMIT, result_ready_i = 1 and ex_valid_i = 1 in the same cycle -> pop only, count_o = DEPTH-1; the push is accepted the next cycle.
REQ-041 Assert rst_ni = 0 with 3 entries queued and one EMIT pending -> result_valid_o = 0 and count_o = 0 immediately; after release, id-table state from before reset causes no output.
